// File: rtl/cobra_ctrl_pkg.sv
// Shared encodings for the cobra run controller.
//   state_e : controller state, exactly as presented on state_o
//   cmd_e   : debug command, exactly as presented on cmd_i
package cobra_ctrl_pkg;

    typedef enum logic [1:0] {
        StHalted = 2'b00,
        StRun    = 2'b01,
        StStep   = 2'b10,
        StCrst   = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CmdHalt      = 2'b00,
        CmdRun       = 2'b01,
        CmdStep      = 2'b10,
        CmdCoreReset = 2'b11
    } cmd_e;

endpackage

// File: rtl/cobra_run_ctrl.sv
// Run/halt/step controller for a simple core with a single PC breakpoint.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   cmd_valid_i/cmd_i      command request (HALT/RUN/STEP/CORE_RESET), cmd_ready_o handshake
//   step_cnt_i             instruction count for STEP (0 treated as 1)
//   pc_i, bp_en_i, bp_addr_i  current PC and breakpoint configuration
//   core_en_o              core advance enable
//   core_rst_o             synchronous reset request to the core (2 cycles)
//   state_o                current state
//   bp_hit_o               one-cycle pulse after a breakpoint halt
//   retired_o              count of enabled cycles, wraps
module cobra_run_ctrl
    import cobra_ctrl_pkg::*;
#(
    parameter int unsigned STEP_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              cmd_valid_i,
    input  logic [1:0]        cmd_i,
    input  logic [STEP_W-1:0] step_cnt_i,
    output logic              cmd_ready_o,
    input  logic [31:0]       pc_i,
    input  logic              bp_en_i,
    input  logic [31:0]       bp_addr_i,
    output logic              core_en_o,
    output logic              core_rst_o,
    output logic [1:0]        state_o,
    output logic              bp_hit_o,
    output logic [31:0]       retired_o
);

    localparam logic [STEP_W-1:0] StepOne = {{(STEP_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    logic              skip_q, skip_d;
    logic              crst_cnt_q, crst_cnt_d;
    logic              bp_hit_q, bp_hit_d;
    logic [31:0]       retired_q, retired_d;

    logic active;
    logic bp_match;
    logic core_en;
    logic accept;
    cmd_e cmd;

    assign cmd      = cmd_e'(cmd_i);
    assign active   = (state_q == StRun) || (state_q == StStep);
    // skip_q masks the breakpoint for the first cycle after a resume so a core
    // parked on the breakpoint PC can move past it.
    assign bp_match = bp_en_i && (pc_i == bp_addr_i) && !skip_q;
    assign core_en  = active && !bp_match;
    assign cmd_ready_o = (state_q == StHalted) || (state_q == StRun);
    assign accept   = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        skip_d      = 1'b0;
        crst_cnt_d  = 1'b0;
        bp_hit_d    = 1'b0;
        retired_d   = core_en ? retired_q + 32'd1 : retired_q;

        unique case (state_q)
            StHalted: begin
                if (accept) begin
                    unique case (cmd)
                        CmdRun: begin
                            state_d = StRun;
                            skip_d  = 1'b1;
                        end
                        CmdStep: begin
                            state_d     = StStep;
                            skip_d      = 1'b1;
                            remaining_d = (step_cnt_i == '0) ? StepOne : step_cnt_i;
                        end
                        CmdCoreReset: state_d = StCrst;
                        CmdHalt: ;
                    endcase
                end
            end
            StRun: begin
                // Core reset beats a breakpoint, which beats a halt request.
                if (accept && cmd == CmdCoreReset) begin
                    state_d = StCrst;
                end else if (bp_match) begin
                    state_d  = StHalted;
                    bp_hit_d = 1'b1;
                end else if (accept && cmd == CmdHalt) begin
                    state_d = StHalted;
                end
            end
            StStep: begin
                if (bp_match) begin
                    state_d     = StHalted;
                    bp_hit_d    = 1'b1;
                    remaining_d = '0;
                end else if (remaining_q <= StepOne) begin
                    state_d     = StHalted;
                    remaining_d = '0;
                end else begin
                    remaining_d = remaining_q - StepOne;
                end
            end
            StCrst: begin
                if (crst_cnt_q) begin
                    state_d = StHalted;
                end else begin
                    crst_cnt_d = 1'b1;
                end
            end
        endcase

        // Retired count reads zero from the first core-reset cycle onward.
        if (state_d == StCrst) begin
            retired_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StHalted;
            remaining_q <= '0;
            skip_q      <= 1'b0;
            crst_cnt_q  <= 1'b0;
            bp_hit_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            skip_q      <= skip_d;
            crst_cnt_q  <= crst_cnt_d;
            bp_hit_q    <= bp_hit_d;
            retired_q   <= retired_d;
        end
    end

    assign core_en_o  = core_en;
    assign core_rst_o = (state_q == StCrst);
    assign state_o    = state_q;
    assign bp_hit_o   = bp_hit_q;
    assign retired_o  = retired_q;

endmodule

// File: doc/cobra_run_ctrl.md
COBRA_RUN_CTRL -- requirements
Module: cobra_run_ctrl

Interface
REQ-001 SHALL have parameter STEP_W, default 8, width of the step-count field.
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-004 SHALL have port cmd_valid_i  input  1  command request.
REQ-005 SHALL have port cmd_i  input  2  command: 00 HALT, 01 RUN, 10 STEP, 11 CORE_RESET.
REQ-006 SHALL have port step_cnt_i  input  STEP_W  instructions to execute for STEP, sampled on acceptance.
REQ-007 SHALL have port cmd_ready_o  output  1  command accepted when cmd_valid_i && cmd_ready_o at the clock edge.
REQ-008 SHALL have port pc_i  input  32  current core PC.
REQ-009 SHALL have port bp_en_i  input  1  breakpoint enable.
REQ-010 SHALL have port bp_addr_i  input  32  breakpoint PC.
REQ-011 SHALL have port core_en_o  output  1  core advance enable (gates PC update and RF write).
REQ-012 SHALL have port core_rst_o  output  1  synchronous reset request to the core.
REQ-013 SHALL have port state_o  output  2  00 HALTED, 01 RUN, 10 STEP, 11 CRST.
REQ-014 SHALL have port bp_hit_o  output  1  one-cycle pulse on breakpoint halt.
REQ-015 SHALL have port retired_o  output  32  count of cycles with core_en_o=1.

Function
REQ-016 SHALL implement a four-state FSM HALTED, RUN, STEP, CRST encoded as state_o.
REQ-017 SHALL drive cmd_ready_o=1 in HALTED and RUN, 0 in STEP and CRST.
REQ-018 HALTED: accepted RUN -> RUN; STEP -> STEP with remaining = (step_cnt_i==0 ? 1 : step_cnt_i); CORE_RESET -> CRST; HALT -> stays HALTED.
REQ-019 RUN: accepted HALT -> HALTED next cycle; CORE_RESET -> CRST; RUN/STEP accepted and ignored.
REQ-020 bp_match SHALL be bp_en_i && pc_i==bp_addr_i && !skip, where skip is set on the edge entering RUN or STEP and cleared after that state's first cycle.
REQ-021 core_en_o SHALL be 1 in RUN and STEP only, and 0 combinationally in any cycle where bp_match=1.
REQ-022 bp_match in RUN or STEP SHALL transition to HALTED next edge and assert bp_hit_o for exactly that following cycle.
REQ-023 STEP: remaining decrements each cycle with core_en_o=1; when it reaches 1 and core_en_o=1, next state HALTED; exactly N enabled cycles total without breakpoint.
REQ-024 CRST: core_rst_o=1, core_en_o=0 for exactly 2 cycles, retired_o cleared to 0, then HALTED.
REQ-025 Priority at one edge: accepted CORE_RESET > bp_match > accepted HALT; bp_hit_o SHALL still pulse if bp_match coincides with accepted HALT.
REQ-026 In the cycle a HALT is accepted core_en_o remains 1 (halt takes effect next cycle).
REQ-027 retired_o SHALL increment by 1 per cycle with core_en_o=1 and wrap 0xFFFF_FFFF -> 0.

Reset
REQ-028 On rst_ni=0, asynchronously: state HALTED, remaining 0, skip 0, retired_o 0, bp_hit_o 0, core_rst_o 0, core_en_o 0, cmd_ready_o 1.
REQ-029 Reset asserted mid-STEP or mid-CRST SHALL abandon the operation; no residual pulses after release.

Structure
REQ-030 State enum and command encodings SHALL live in a shared package cobra_ctrl_pkg.
REQ-031 SHALL be a single module; no sub-modules.

Verification
REQ-032 Reset, then RUN with bp_en_i=0 for 10 cycles, HALT -> core_en_o=1 for 11 cycles (incl. accept cycle), retired_o=11, state_o=00.
REQ-033 STEP with step_cnt_i=3 -> core_en_o=1 exactly 3 cycles, cmd_ready_o=0 throughout, then HALTED; step_cnt_i=0 -> exactly 1 cycle.
REQ-034 bp_addr_i=0x10, RUN, pc_i reaches 0x10 -> core_en_o=0 that cycle, bp_hit_o one pulse, HALTED; RUN again at pc_i=0x10 -> advances (skip).
REQ-035 CORE_RESET while in RUN with retired_o=5 -> core_rst_o high 2 cycles, retired_o=0, then HALTED.
REQ-036 HALT accepted same cycle as bp_match -> HALTED, bp_hit_o pulses; rst_ni low mid-STEP -> all outputs at reset values immediately.
REQ-037 Force retired_o=0xFFFF_FFFF, one enabled cycle -> retired_o=0.
